dct_mac_array: RTL and testbench

Parametrised multi-lane multiply-accumulate unit for the forward DCT datapath. It is the successor to the single-lane `macu` inside each `dct_unit`. One input sample stream is broadcast to `LANES` lanes, each with its own coefficient. Each lane accumulates `TAPS` products into one DCT coefficient, then rounds, shifts and saturates it. All lanes are released together through a valid/ready output register with backpressure.

---
 rtl/dct_mac_pkg.sv | 52 +++++
 rtl/dct_mac_lane.sv | 65 ++++++
 rtl/dct_mac_array.sv | 118 +++++++++++
 tb/tb_dct_mac_array.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_mac_pkg.sv
// -----------------------------------------------------------------------------
// dct_mac_pkg
// Shared types and helpers for the multi-lane DCT multiply-accumulate array.
//   acc_width()       : accumulator width that cannot overflow over a block
//   round_shift_sat() : optional round-half-up, arithmetic shift, clamp + flag
//   lane_lsb()        : LSB position of a lane inside a flat lane bus
// -----------------------------------------------------------------------------
package dct_mac_pkg;

    // Widest intermediate used by the result post-processing.
    localparam int MAXW = 64;

    typedef struct packed {
        logic signed [MAXW-1:0] value;
        logic                   sat;
    } rss_t;

    function automatic int acc_width(input int dw, input int cw, input int taps);
        return dw + cw + $clog2(taps);
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    // The bias is added in MAXW bits, so it can never wrap the accumulator sum.
    function automatic rss_t round_shift_sat(input logic signed [MAXW-1:0] sum,
                                             input int                     frac,
                                             input int                     rw,
                                             input bit                     rnd);
        logic signed [MAXW-1:0] biased;
        logic signed [MAXW-1:0] shifted;
        logic signed [MAXW-1:0] hi;
        logic signed [MAXW-1:0] lo;
        rss_t                   r;
        biased  = rnd ? sum + (64'sd1 <<< (frac - 1)) : sum;
        shifted = biased >>> frac;
        hi      = (64'sd1 <<< (rw - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (rw - 1));
        r.value = shifted;
        r.sat   = 1'b0;
        if (shifted > hi) begin
            r.value = hi;
            r.sat   = 1'b1;
        end else if (shifted < lo) begin
            r.value = lo;
            r.sat   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dct_mac_lane.sv
// -----------------------------------------------------------------------------
// dct_mac_lane
// One MAC lane: registered product, block accumulator, and the combinational
// round/shift/saturate of the final sum (accumulator + last product).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_load     : capture i_data * i_coef into the product register
//   i_step     : advance the accumulator with the registered product
//   i_first    : registered product is tap 0 of a block (restart accumulator)
//   i_data     : signed sample, i_coef : signed coefficient
//   o_res      : rounded/saturated result of acc + product
//   o_sat      : o_res was clamped
// -----------------------------------------------------------------------------
module dct_mac_lane
    import dct_mac_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CW    = 12,
    parameter int TAPS  = 8,
    parameter int RW    = 12,
    parameter int FRAC  = 11,
    parameter int ROUND = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic                 i_first,
    input  logic signed [DW-1:0] i_data,
    input  logic signed [CW-1:0] i_coef,
    output logic signed [RW-1:0] o_res,
    output logic                 o_sat
);

    localparam int PW = DW + CW;
    localparam int AW = acc_width(DW, CW, TAPS);

    logic signed [PW-1:0] r_mult_res;
    logic signed [AW-1:0] r_acc;
    logic signed [AW-1:0] w_mult_ext;
    logic signed [AW-1:0] w_sum;
    rss_t                 w_rs;
    logic                 w_unused_hi;

    assign w_mult_ext = AW'(r_mult_res);
    assign w_sum      = r_acc + w_mult_ext;
    assign w_rs       = round_shift_sat(MAXW'(w_sum), FRAC, RW, ROUND != 0);
    assign o_res      = w_rs.value[RW-1:0];
    assign o_sat      = w_rs.sat;
    // After clamping, everything above RW is sign extension.
    assign w_unused_hi = ^w_rs.value[MAXW-1:RW];

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mult_res <= '0;
            r_acc      <= '0;
        end else begin
            if (i_load) r_mult_res <= PW'(i_data) * PW'(i_coef);
            if (i_step) r_acc      <= i_first ? w_mult_ext : w_sum;
        end
    end

endmodule

// File: rtl/dct_mac_array.sv
// -----------------------------------------------------------------------------
// dct_mac_array
// LANES parallel MAC lanes sharing one sample stream. Each lane accumulates
// TAPS products, then rounds, shifts and saturates; all lanes are released
// together through a valid/ready output register with backpressure.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input beat handshake
//   in_data              : signed sample broadcast to every lane
//   in_coef              : per-lane signed coefficients, lane l at [l*CW +: CW]
//   out_valid/out_ready  : result handshake
//   out_data             : per-lane results, lane l at [l*RW +: RW]
//   out_sat              : per-lane saturation flags
// -----------------------------------------------------------------------------
module dct_mac_array
    import dct_mac_pkg::*;
#(
    parameter int LANES = 8,
    parameter int TAPS  = 8,
    parameter int DW    = 8,
    parameter int CW    = 12,
    parameter int RW    = 12,
    parameter int FRAC  = 11,
    parameter int ROUND = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [DW-1:0]   in_data,
    input  logic [LANES*CW-1:0]    in_coef,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*RW-1:0]    out_data,
    output logic [LANES-1:0]       out_sat
);

    localparam int TW = $clog2(TAPS);

    logic [TW-1:0]          r_tap;
    logic                   r_v1;
    logic                   r_first1;
    logic                   r_last1;
    logic                   r_out_valid;
    logic [LANES*RW-1:0]    r_out_data;
    logic [LANES-1:0]       r_out_sat;

    logic                   w_stall;
    logic                   w_accept;
    logic                   w_step;
    logic                   w_load;
    logic [LANES*RW-1:0]    w_res;
    logic [LANES-1:0]       w_sat;

    // A full output register that is not being drained freezes the whole pipe.
    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = !rst && !w_stall;
    assign w_accept = in_valid && in_ready;
    assign w_step   = r_v1 && !w_stall;
    assign w_load   = w_step && r_last1;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        dct_mac_lane #(
            .DW    (DW),
            .CW    (CW),
            .TAPS  (TAPS),
            .RW    (RW),
            .FRAC  (FRAC),
            .ROUND (ROUND)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_accept),
            .i_step  (w_step),
            .i_first (r_first1),
            .i_data  (in_data),
            .i_coef  (in_coef[lane_lsb(g, CW) +: CW]),
            .o_res   (w_res[lane_lsb(g, RW) +: RW]),
            .o_sat   (w_sat[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tap       <= '0;
            r_v1        <= 1'b0;
            r_first1    <= 1'b0;
            r_last1     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= '0;
        end else begin
            if (w_accept) begin
                r_tap <= (r_tap == TW'(TAPS - 1)) ? '0 : r_tap + TW'(1);
            end
            if (!w_stall) begin
                r_v1 <= w_accept;
                if (w_accept) begin
                    r_first1 <= (r_tap == '0);
                    r_last1  <= (r_tap == TW'(TAPS - 1));
                end
            end
            // A new result takes priority over a simultaneous drain.
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_res;
                r_out_sat   <= w_sat;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dct_mac_array.sv
module tb_dct_mac_array;

    localparam int LANES = 8;
    localparam int TAPS  = 8;
    localparam int DW    = 8;
    localparam int CW    = 12;
    localparam int RW    = 12;
    localparam int RW_S  = 10;
    localparam int FRAC  = 11;

    typedef struct packed {
        logic [95:0] d;
        logic [7:0]  s;
    } res_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    out_ready = 1'b1;
    logic signed [DW-1:0]    in_data = '0;
    logic [LANES*CW-1:0]     in_coef = '0;

    logic                    rdy_d, rdy_r, rdy_s;
    logic                    ov_d, ov_r, ov_s;
    logic [LANES*RW-1:0]     od_d, od_r;
    logic [LANES*RW_S-1:0]   od_s;
    logic [LANES-1:0]        os_d, os_r, os_s;

    int     n_checks = 0;
    int     n_pass   = 0;
    res_t   exp_q[3][$];
    longint psum[3][LANES];
    int     beats[3];

    always #5 clk = ~clk;

    dct_mac_array #(.LANES(LANES), .TAPS(TAPS), .DW(DW), .CW(CW), .RW(RW),
                    .FRAC(FRAC), .ROUND(1)) u_dut_def (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_d),
        .in_data(in_data), .in_coef(in_coef), .out_valid(ov_d),
        .out_ready(out_ready), .out_data(od_d), .out_sat(os_d));

    dct_mac_array #(.LANES(LANES), .TAPS(TAPS), .DW(DW), .CW(CW), .RW(RW),
                    .FRAC(FRAC), .ROUND(0)) u_dut_trunc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_r),
        .in_data(in_data), .in_coef(in_coef), .out_valid(ov_r),
        .out_ready(out_ready), .out_data(od_r), .out_sat(os_r));

    dct_mac_array #(.LANES(LANES), .TAPS(TAPS), .DW(DW), .CW(CW), .RW(RW_S),
                    .FRAC(FRAC), .ROUND(1)) u_dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s),
        .in_data(in_data), .in_coef(in_coef), .out_valid(ov_s),
        .out_ready(out_ready), .out_data(od_s), .out_sat(os_s));

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic check_vec(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Signed value of lane l (width lw) from a flat bus.
    function automatic longint lane_val(input logic [95:0] d, input int l, input int lw);
        logic [95:0] t;
        longint      r;
        t = d >> (l * lw);
        r = longint'(t[63:0]) & ((longint'(1) << lw) - 1);
        if (r >= (longint'(1) << (lw - 1))) r -= (longint'(1) << lw);
        return r;
    endfunction

    // Reference: optional +2^(FRAC-1), floor-divide by 2^FRAC, clamp to rw bits.
    function automatic void expect_lane(input longint sum, input int rw, input bit rnd,
                                        output longint v, output bit s);
        longint t, hi, lo;
        t  = rnd ? sum + (longint'(1) << (FRAC - 1)) : sum;
        t  = t >>> FRAC;
        hi = (longint'(1) << (rw - 1)) - 1;
        lo = -(longint'(1) << (rw - 1));
        v  = t;
        s  = 1'b0;
        if (t > hi) begin v = hi; s = 1'b1; end
        if (t < lo) begin v = lo; s = 1'b1; end
    endfunction

    function automatic res_t build_exp(input int k);
        res_t        e;
        longint      v;
        bit          s;
        int          lw;
        logic [95:0] m;
        lw = (k == 2) ? RW_S : RW;
        m  = (96'd1 << lw) - 96'd1;
        e  = '0;
        for (int l = 0; l < LANES; l++) begin
            expect_lane(psum[k][l], lw, k != 1, v, s);
            e.d = e.d | ((96'(v) & m) << (l * lw));
            e.s[l] = s;
        end
        return e;
    endfunction

    // Compare, then model update, on every falling edge.
    always @(negedge clk) begin
        logic        v[3];
        logic        r[3];
        logic [95:0] d[3];
        logic [7:0]  s[3];
        v = '{ov_d, ov_r, ov_s};
        r = '{rdy_d, rdy_r, rdy_s};
        d = '{96'(od_d), 96'(od_r), 96'(od_s)};
        s = '{os_d, os_r, os_s};
        for (int k = 0; k < 3; k++) begin
            if (v[k]) begin
                if (exp_q[k].size() == 0) begin
                    check($sformatf("spurious_out_valid[%0d]", k), 1, 0);
                end else begin
                    check_vec($sformatf("out_data[%0d]", k), d[k], exp_q[k][0].d);
                    check_vec($sformatf("out_sat[%0d]", k), 96'(s[k]), 96'(exp_q[k][0].s));
                    if (out_ready && !rst) void'(exp_q[k].pop_front());
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                exp_q[k].delete();
                beats[k] = 0;
                for (int l = 0; l < LANES; l++) psum[k][l] = 0;
            end else if (in_valid && r[k]) begin
                for (int l = 0; l < LANES; l++)
                    psum[k][l] += longint'(in_data) * longint'($signed(in_coef[l*CW +: CW]));
                beats[k]++;
                if (beats[k] == TAPS) begin
                    exp_q[k].push_back(build_exp(k));
                    beats[k] = 0;
                    for (int l = 0; l < LANES; l++) psum[k][l] = 0;
                end
            end
        end
    end

    task automatic set_coef(input logic signed [CW-1:0] c);
        for (int l = 0; l < LANES; l++) in_coef[l*CW +: CW] = c;
    endtask

    // Offer one beat and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send_beat(input logic signed [DW-1:0] dv);
        bit taken;
        taken    = 1'b0;
        in_valid = 1'b1;
        in_data  = dv;
        for (int i = 0; i < 200 && !taken; i++) begin
            @(negedge clk);
            taken = rdy_d;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!taken) check("send_beat_timeout", 0, 1);
    endtask

    // Called right after the last beat of a block: 2-cycle latency, then valid.
    task automatic wait_result(input string name);
        @(negedge clk);
        check({name, "_valid_not_early"}, ov_d, 0);
        @(negedge clk);
        check({name, "_valid_at_latency"}, ov_d, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int spur;

        // Reset
        @(negedge clk);
        check("in_ready_during_reset", rdy_d, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", ov_d, 0);
        check_vec("reset_out_data", 96'(od_d), 96'd0);
        check("reset_out_sat", os_d, 0);
        check("in_ready_after_reset", rdy_d, 1);
        @(posedge clk); #1;

        // Basic accumulate: 8 x (1 * 1024) = 8192 -> (8192+1024)>>11 = 4
        set_coef(12'sd1024);
        repeat (TAPS) send_beat(8'sd1);
        wait_result("basic");
        check("basic_lane0", lane_val(96'(od_d), 0, RW), 4);
        check("basic_lane7", lane_val(96'(od_d), 7, RW), 4);
        check("basic_sat", os_d, 0);
        @(posedge clk); #1;

        // Rounding: sum 1024 -> 1 when rounding, 0 when truncating
        send_beat(8'sd1);
        repeat (TAPS - 1) send_beat(8'sd0);
        wait_result("round");
        check("round_half_up", lane_val(96'(od_d), 0, RW), 1);
        check("round_truncate", lane_val(96'(od_r), 0, RW), 0);
        @(posedge clk); #1;

        // Saturation on the RW=10 instance; lane 7 has coefficient 0
        set_coef(12'sd2047);
        in_coef[7*CW +: CW] = '0;
        repeat (TAPS) send_beat(8'sd127);
        wait_result("sat_pos");
        check("sat_pos_lane0", lane_val(96'(od_s), 0, RW_S), 511);
        check("sat_pos_flag0", os_s[0], 1);
        check("sat_zero_lane7", lane_val(96'(od_s), 7, RW_S), 0);
        check("sat_zero_flag7", os_s[7], 0);
        @(posedge clk); #1;
        repeat (TAPS) send_beat(-8'sd128);
        wait_result("sat_neg");
        check("sat_neg_lane0", lane_val(96'(od_s), 0, RW_S), -512);
        check("sat_neg_flag0", os_s[0], 1);
        @(posedge clk); #1;

        // Backpressure: first result held while the second block stalls
        set_coef(12'sd1024);
        out_ready = 1'b0;
        repeat (TAPS) send_beat(8'sd1);
        fork
            begin
                repeat (6) @(negedge clk);
                check("bp_in_ready_low", rdy_d, 0);
                check("bp_out_valid_held", ov_d, 1);
                check("bp_first_result_held", lane_val(96'(od_d), 0, RW), 4);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join_none
        repeat (TAPS) send_beat(8'sd2);
        wait_result("bp_second");
        check("bp_second_lane0", lane_val(96'(od_d), 0, RW), 8);
        @(posedge clk); #1;

        // Reset mid-block discards the partial sum
        repeat (3) send_beat(8'sd50);
        rst = 1'b1;
        @(negedge clk);
        check("in_ready_mid_reset", rdy_d, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (TAPS) send_beat(8'sd1);
        wait_result("after_reset");
        check("after_reset_lane0", lane_val(96'(od_d), 0, RW), 4);
        spur = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ov_d) spur++;
        end
        check("no_spurious_after_reset", spur, 0);
        @(posedge clk); #1;

        // Gapped random traffic with random backpressure
        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom_range(99) < 30);
            in_data   = DW'($urandom);
            for (int l = 0; l < LANES; l++) in_coef[l*CW +: CW] = CW'($urandom);
            out_ready = ($urandom_range(99) < 75);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            check($sformatf("drained_results[%0d]", k), exp_q[k].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
